// File: rtl/rx_packet_writer.sv
// rx_packet_writer: UART RX packet sequencer for commit/rollback FIFO; `define RX_PKT_CRC8_EN adds CRC-8 packet check
module rx_packet_writer #(
  parameter int IDLE_TICKS = 3125,
  parameter int MAX_LEN    = 64,
  parameter int CNT_W      = 16
) (
  input  logic             writeClk,
  input  logic             reset,
  input  logic             rxValid,
  input  logic [7:0]       rxByte,
  input  logic             rxErr,
  input  logic             fifoFull,
  output logic [8:0]       fifoData,
  output logic             fifoWriteEn,
  output logic             fifoCommit,
  output logic             fifoRollback,
  output logic             busy,
  output logic [CNT_W-1:0] pktCount,
  output logic [CNT_W-1:0] dropCount
);
  localparam int IW = $clog2(IDLE_TICKS);
  localparam int LW = $clog2(MAX_LEN + 1);
  typedef enum logic [2:0] {IDLE, RECV, COMMIT, ROLLBACK, DROP} state_t;
  state_t state, nextState;
  logic [IW-1:0] idleCnt;
  logic [LW-1:0] len;
  logic skidValid, skidErr;
  logic [7:0] skidByte;
  logic inValid, inErr, expired, accept, first, crcOk;
  logic [7:0] inByte;
  assign inValid = skidValid || rxValid;
  assign inByte  = skidValid ? skidByte : rxByte;
  assign inErr   = skidValid ? skidErr : rxErr;
  assign expired = !rxValid && idleCnt == IW'(IDLE_TICKS - 1);
`ifdef RX_PKT_CRC8_EN
  logic [7:0] crc;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? {x[6:0], 1'b0} ^ 8'h07 : {x[6:0], 1'b0};
    return x;
  endfunction
  assign crcOk = crc == 8'h00 && len != LW'(1);
  always_ff @(posedge writeClk or posedge reset)
    if (reset) crc <= '0;
    else if (accept) crc <= crc8(first ? 8'h00 : crc, inByte);
`else
  assign crcOk = 1'b1;
`endif
  always_ff @(posedge writeClk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    accept = 1'b0;
    first = 1'b0;
    case (state)
      IDLE: if (inValid) begin
        nextState = (inErr || fifoFull) ? DROP : RECV;
        accept = !inErr && !fifoFull;
        first = 1'b1;
      end
      RECV: if (rxValid) begin
        if (rxErr || fifoFull || len == LW'(MAX_LEN)) nextState = ROLLBACK;
        else accept = 1'b1;
      end else if (expired) nextState = crcOk ? COMMIT : ROLLBACK;
      COMMIT:   nextState = IDLE;
      ROLLBACK: nextState = DROP;
      DROP:     nextState = expired ? IDLE : DROP;
      default:  nextState = IDLE;
    endcase
  end
  always_comb begin
    fifoCommit   = state == COMMIT;
    fifoRollback = state == ROLLBACK;
    busy         = state != IDLE;
  end
  // Idle counter only runs while a packet or drop is in progress; it saturates at expiry
  always_ff @(posedge writeClk or posedge reset)
    if (reset) begin
      idleCnt     <= '0;
      len         <= '0;
      skidValid   <= 1'b0;
      skidByte    <= '0;
      skidErr     <= 1'b0;
      fifoData    <= '0;
      fifoWriteEn <= 1'b0;
      pktCount    <= '0;
      dropCount   <= '0;
    end else begin
      idleCnt     <= (rxValid || !(state inside {RECV, DROP})) ? '0 :
                     (idleCnt == IW'(IDLE_TICKS - 1)) ? idleCnt : idleCnt + 1'b1;
      len         <= accept ? (first ? LW'(1) : len + 1'b1) : len;
      skidValid   <= state == COMMIT && rxValid;
      skidByte    <= rxByte;
      skidErr     <= rxErr;
      fifoWriteEn <= accept;
      fifoData    <= accept ? {first, inByte} : fifoData;
      pktCount    <= pktCount + CNT_W'(state == COMMIT);
      dropCount   <= dropCount + CNT_W'(state == ROLLBACK);
    end
endmodule

// File: tb/tb_rx_packet_writer.sv
// tb_rx_packet_writer: directed stimulus with a queue-based scoreboard on the FIFO strobes
module tb_rx_packet_writer;
  localparam int T = 40;
  localparam int L = 8;
  logic writeClk = 1'b0, reset = 1'b1, rxValid = 1'b0, rxErr = 1'b0, fifoFull = 1'b0;
  logic [7:0] rxByte = '0;
  logic [8:0] fifoData;
  logic fifoWriteEn, fifoCommit, fifoRollback, busy;
  logic [15:0] pktCount, dropCount;
  int tests = 0, fails = 0, cyc = 0, lastWr = 0;
  typedef struct packed {logic [1:0] k; logic [8:0] d;} ev_t;
  ev_t expQ[$];
  ev_t got, want;

  always #5 writeClk = ~writeClk;

  rx_packet_writer #(.IDLE_TICKS(T), .MAX_LEN(L), .CNT_W(16)) dut (
    .writeClk(writeClk), .reset(reset), .rxValid(rxValid), .rxByte(rxByte), .rxErr(rxErr),
    .fifoFull(fifoFull), .fifoData(fifoData), .fifoWriteEn(fifoWriteEn), .fifoCommit(fifoCommit),
    .fifoRollback(fifoRollback), .busy(busy), .pktCount(pktCount), .dropCount(dropCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic strobe(input logic [7:0] b, input logic e);
    rxValid = 1'b1; rxByte = b; rxErr = e;
    @(negedge writeClk);
    rxValid = 1'b0; rxErr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge writeClk);
  endtask

  task automatic expW(input logic [8:0] d); expQ.push_back({2'd0, d}); endtask
  task automatic expC(); expQ.push_back({2'd1, 9'd0}); endtask
  task automatic expR(); expQ.push_back({2'd2, 9'd0}); endtask

  // Monitor: every strobe must match the next queued expectation; commits land T cycles after the last write
  initial forever begin
    @(negedge writeClk);
    cyc++;
    if (fifoWriteEn || fifoCommit || fifoRollback) begin
      check("strobe_excl", $countones({fifoWriteEn, fifoCommit, fifoRollback}), 1);
      got = {fifoWriteEn ? 2'd0 : fifoCommit ? 2'd1 : 2'd2, fifoWriteEn ? fifoData : 9'd0};
      if (expQ.size() == 0) check("event_pending", expQ.size(), 1);
      else begin
        want = expQ.pop_front();
        check("event", got, want);
      end
      if (fifoCommit) check("commit_gap", cyc - lastWr, T);
      if (fifoWriteEn) lastWr = cyc;
    end
  end

  initial begin
    idle(3);
    check("rst_data", fifoData, 0);
    check("rst_strobes", {fifoWriteEn, fifoCommit, fifoRollback}, 0);
    check("rst_busy", busy, 0);
    check("rst_cnts", {pktCount, dropCount}, 0);
    reset = 1'b0;
    idle(2);
`ifdef RX_PKT_CRC8_EN
    expW(9'h101); expW(9'h007); expC();
    strobe(8'h01, 0); strobe(8'h07, 0);
    idle(T + 5);
    check("crc_ok_pkt", pktCount, 1);
    expW(9'h101); expW(9'h008); expR();
    strobe(8'h01, 0); strobe(8'h08, 0);
    idle(2 * T + 5);
    check("crc_bad_drop", dropCount, 1);
    check("crc_bad_pkt", pktCount, 1);
    check("crc_idle", busy, 0);
`else
    // Two-byte packet commits
    expW(9'h118); expW(9'h064); expC();
    strobe(8'h18, 0); strobe(8'h64, 0);
    idle(T + 5);
    check("t1_pkt", pktCount, 1);
    check("t1_held", fifoData, 9'h064);
    check("t1_busy", busy, 0);
    // Error byte rolls back, later bytes dropped until idle
    expW(9'h111); expW(9'h022); expR();
    strobe(8'h11, 0); strobe(8'h22, 0); strobe(8'h33, 1);
    idle(5); strobe(8'h44, 0); idle(5); strobe(8'h45, 0); idle(3);
    check("t2_dropping", busy, 1);
    idle(T + 5);
    check("t2_drop", dropCount, 1);
    check("t2_busy", busy, 0);
    // Overlength packet
    for (int i = 0; i < L; i++) expW({i == 0, 8'h40 + 8'(i)});
    expR();
    for (int i = 0; i <= L; i++) strobe(8'h40 + 8'(i), 0);
    idle(2 * T + 5);
    check("t3_drop", dropCount, 2);
    check("t3_pkt", pktCount, 1);
    // FIFO full mid-packet, then a clean packet
    expW(9'h155); expW(9'h056); expR();
    strobe(8'h55, 0); strobe(8'h56, 0);
    fifoFull = 1'b1; strobe(8'h57, 0);
    idle(T + 5);
    fifoFull = 1'b0;
    idle(T);
    check("t4_drop", dropCount, 3);
    expW(9'h177); expW(9'h078); expC();
    strobe(8'h77, 0); strobe(8'h78, 0);
    idle(T + 5);
    check("t4_pkt", pktCount, 2);
    // Byte in expiry cycle joins; byte in COMMIT cycle starts the next packet
    expW(9'h101); expW(9'h002); expC(); expW(9'h103); expC();
    strobe(8'h01, 0); idle(T - 1);
    strobe(8'h02, 0); idle(T);
    strobe(8'h03, 0);
    idle(T + 10);
    check("t5_pkt", pktCount, 4);
    check("t5_drop", dropCount, 3);
`endif
    // Asynchronous reset in RECV
    expW(9'h161); expW(9'h062);
    strobe(8'h61, 0); strobe(8'h62, 0); idle(3);
    check("t6_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_busy0", busy, 0);
    check("t6_data", fifoData, 0);
    check("t6_strobes", {fifoWriteEn, fifoCommit, fifoRollback}, 0);
    check("t6_cnts", {pktCount, dropCount}, 0);
    @(negedge writeClk);
    reset = 1'b0;
    idle(T + 5);
    check("t6_nocommit", {pktCount, dropCount}, 0);
    check("queue_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
